// File: rtl/census_signature_gen.sv
// ============================================================================
// census_signature_gen: shifts one (nbr < center) bit per neighbor beat into a
// WIDTH-bit census signature. Optional macro CENSUS_SIG_ONES_EN adds sig_ones.
// Revision: 1.0
// ============================================================================
`default_nettype none

module census_signature_gen #(
  parameter int WIDTH      = 32,
  parameter int PIXEL_BITS = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [PIXEL_BITS-1:0]         center_pixel,
  output logic                          start_ready,
  input  logic                          nbr_valid,
  input  logic [PIXEL_BITS-1:0]         nbr_pixel,
  output logic                          nbr_ready,
  output logic                          sig_valid,
  output logic [WIDTH-1:0]              sig,
`ifdef CENSUS_SIG_ONES_EN
  output logic [$clog2(WIDTH+1)-1:0]    sig_ones,
`endif
  input  logic                          sig_ready
);

  localparam int CNT_W  = $clog2(WIDTH);
  localparam int ONES_W = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PIXEL_BITS-1:0]   center_q, center_d;
  logic [WIDTH-1:0]        sig_q, sig_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ONES_W-1:0]       ones_q, ones_d;
  logic                    cmp_bit;
  logic                    load;

  assign cmp_bit = (nbr_pixel < center_q);

  always_comb begin
    state_d     = state_q;
    center_d    = center_q;
    sig_d       = sig_q;
    cnt_d       = cnt_q;
    ones_d      = ones_q;
    start_ready = 1'b0;
    nbr_ready   = 1'b0;
    sig_valid   = 1'b0;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        load        = start;
      end
      COLLECT: begin
        nbr_ready = 1'b1;
        if (nbr_valid) begin
          sig_d  = {sig_q[WIDTH-2:0], cmp_bit};
          ones_d = ones_q + {{(ONES_W-1){1'b0}}, cmp_bit};
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        sig_valid   = 1'b1;
        start_ready = sig_ready;
        if (sig_ready) begin
          state_d = IDLE;
          load    = start;
        end
      end
      default: state_d = IDLE;
    endcase

    // A start in IDLE, or one paired with sig_ready in HOLD, opens a new window.
    if (load) begin
      center_d = center_pixel;
      sig_d    = '0;
      cnt_d    = '0;
      ones_d   = '0;
      state_d  = COLLECT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      center_q <= '0;
      sig_q    <= '0;
      cnt_q    <= '0;
      ones_q   <= '0;
    end else begin
      state_q  <= state_d;
      center_q <= center_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      ones_q   <= ones_d;
    end
  end

  assign sig = sig_q;

`ifdef CENSUS_SIG_ONES_EN
  assign sig_ones = ones_q;
`else
  logic unused_ones;
  assign unused_ones = ^ones_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_census_signature_gen.sv
// Directed bench for census_signature_gen: WIDTH=4 instance for handshake,
// stall, back-to-back and async reset cases; WIDTH=32 instance for the wide pattern.
`default_nettype none

module tb_census_signature_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // WIDTH=4 instance
  logic       a_start = 0, a_nbr_valid = 0, a_sig_ready = 0;
  logic [7:0] a_center = 0, a_nbr = 0;
  logic       a_start_ready, a_nbr_ready, a_sig_valid;
  logic [3:0] a_sig;
  logic [2:0] a_ones;

  // WIDTH=32 instance
  logic        b_start = 0, b_nbr_valid = 0, b_sig_ready = 0;
  logic [7:0]  b_center = 0, b_nbr = 0;
  logic        b_start_ready, b_nbr_ready, b_sig_valid;
  logic [31:0] b_sig;
  logic [5:0]  b_ones;

  census_signature_gen #(.WIDTH(4), .PIXEL_BITS(8)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .center_pixel(a_center),
    .start_ready(a_start_ready), .nbr_valid(a_nbr_valid), .nbr_pixel(a_nbr),
    .nbr_ready(a_nbr_ready), .sig_valid(a_sig_valid), .sig(a_sig),
`ifdef CENSUS_SIG_ONES_EN
    .sig_ones(a_ones),
`endif
    .sig_ready(a_sig_ready)
  );

  census_signature_gen #(.WIDTH(32), .PIXEL_BITS(8)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .center_pixel(b_center),
    .start_ready(b_start_ready), .nbr_valid(b_nbr_valid), .nbr_pixel(b_nbr),
    .nbr_ready(b_nbr_ready), .sig_valid(b_sig_valid), .sig(b_sig),
`ifdef CENSUS_SIG_ONES_EN
    .sig_ones(b_ones),
`endif
    .sig_ready(b_sig_ready)
  );

`ifndef CENSUS_SIG_ONES_EN
  assign a_ones = '0;
  assign b_ones = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ones_a(input string tag, input logic [2:0] exp);
`ifdef CENSUS_SIG_ONES_EN
    chk(tag, {29'd0, a_ones}, {29'd0, exp});
`endif
  endtask

  task automatic beat_a(input logic [7:0] px);
    a_nbr_valid = 1'b1;
    a_nbr       = px;
    step();
    a_nbr_valid = 1'b0;
  endtask

  initial begin
    // Reset values
    #1;
    chk("rst_start_ready", {31'd0, a_start_ready}, 32'd1);
    chk("rst_nbr_ready",   {31'd0, a_nbr_ready},   32'd0);
    chk("rst_sig_valid",   {31'd0, a_sig_valid},   32'd0);
    chk("rst_sig",         {28'd0, a_sig},         32'd0);
    chk_ones_a("rst_ones", 3'd0);
    step();
    rst = 1'b0;
    step();

    // Basic window: center 100, neighbors 50,150,100,99
    a_start = 1'b1; a_center = 8'd100;
    step();
    a_start = 1'b0;
    chk("col_nbr_ready",   {31'd0, a_nbr_ready},   32'd1);
    chk("col_start_ready", {31'd0, a_start_ready}, 32'd0);
    beat_a(8'd50); beat_a(8'd150); beat_a(8'd100);
    chk("basic_pre_valid", {31'd0, a_sig_valid}, 32'd0);
    beat_a(8'd99);
    chk("basic_valid", {31'd0, a_sig_valid}, 32'd1);
    chk("basic_sig",   {28'd0, a_sig},       32'h9);
    chk_ones_a("basic_ones", 3'd2);

    // Backpressure: 5 cycles without sig_ready, pending start and nbr_valid
    a_start = 1'b1; a_center = 8'd7; a_nbr_valid = 1'b1; a_nbr = 8'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_sig",         {28'd0, a_sig},         32'h9);
      chk("hold_valid",       {31'd0, a_sig_valid},   32'd1);
      chk("hold_nbr_ready",   {31'd0, a_nbr_ready},   32'd0);
      chk("hold_start_ready", {31'd0, a_start_ready}, 32'd0);
    end
    a_nbr_valid = 1'b0;

    // Back-to-back: sig_ready with start (center 0), then 0,255,0,0
    a_center = 8'd0; a_sig_ready = 1'b1;
    #1;
    chk("b2b_start_ready", {31'd0, a_start_ready}, 32'd1);
    step();
    a_start = 1'b0; a_sig_ready = 1'b0;
    chk("b2b_collect",   {31'd0, a_nbr_ready}, 32'd1);
    chk("b2b_valid_low", {31'd0, a_sig_valid}, 32'd0);
    beat_a(8'd0); beat_a(8'd255); beat_a(8'd0); beat_a(8'd0);
    chk("b2b_valid", {31'd0, a_sig_valid}, 32'd1);
    chk("b2b_sig",   {28'd0, a_sig},       32'h0);
    chk_ones_a("b2b_ones", 3'd0);
    a_sig_ready = 1'b1;
    step();
    a_sig_ready = 1'b0;
    chk("consume_idle",  {31'd0, a_start_ready}, 32'd1);
    chk("consume_valid", {31'd0, a_sig_valid},   32'd0);

    // Stall of 3 cycles between beats 2 and 3
    a_start = 1'b1; a_center = 8'd100;
    step();
    a_start = 1'b0;
    beat_a(8'd50); beat_a(8'd150);
    a_nbr = 8'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", {31'd0, a_sig_valid}, 32'd0);
    end
    beat_a(8'd100);
    chk("stall_pre_valid", {31'd0, a_sig_valid}, 32'd0);
    beat_a(8'd99);
    chk("stall_valid_rise", {31'd0, a_sig_valid}, 32'd1);
    chk("stall_sig",        {28'd0, a_sig},       32'h9);
    chk_ones_a("stall_ones", 3'd2);
    a_sig_ready = 1'b1;
    step();
    a_sig_ready = 1'b0;

    // Async reset after 2 of 4 beats
    a_start = 1'b1; a_center = 8'd100;
    step();
    a_start = 1'b0;
    beat_a(8'd50); beat_a(8'd150);
    #2 rst = 1'b1;
    #1;
    chk("arst_start_ready", {31'd0, a_start_ready}, 32'd1);
    chk("arst_nbr_ready",   {31'd0, a_nbr_ready},   32'd0);
    chk("arst_sig_valid",   {31'd0, a_sig_valid},   32'd0);
    chk("arst_sig",         {28'd0, a_sig},         32'd0);
    chk_ones_a("arst_ones", 3'd0);
    #1 rst = 1'b0;
    step();
    a_start = 1'b1; a_center = 8'd10;
    step();
    a_start = 1'b0;
    beat_a(8'd9); beat_a(8'd9); beat_a(8'd9); beat_a(8'd9);
    chk("post_rst_valid", {31'd0, a_sig_valid}, 32'd1);
    chk("post_rst_sig",   {28'd0, a_sig},       32'hF);
    chk_ones_a("post_rst_ones", 3'd4);

    // WIDTH=32: center 128, neighbors 0,255,0,255,...
    b_start = 1'b1; b_center = 8'd128;
    step();
    b_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      b_nbr_valid = 1'b1;
      b_nbr = (i % 2 == 0) ? 8'd0 : 8'd255;
      step();
    end
    b_nbr_valid = 1'b0;
    chk("w32_valid", {31'd0, b_sig_valid}, 32'd1);
    chk("w32_sig",   b_sig,                32'hAAAAAAAA);
`ifdef CENSUS_SIG_ONES_EN
    chk("w32_ones",  {26'd0, b_ones},      32'd16);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
